// File: rtl/hermes_cmd_queue_if.sv
// Signal bundle between the DMNI MMR front-end / Hermes engine and hermes_cmd_queue.
// master = front-end plus engine side, slave = the queue itself.
interface hermes_cmd_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Handshake: push_i is a one-cycle strobe with no ready; a push the queue cannot
  // take is dropped and flagged by a one-cycle overflow_o pulse in that same cycle.
  logic          push_i;
  logic          push_op_i;
  logic [31:0]   push_size_i;
  logic [31:0]   push_size_2_i;
  logic [31:0]   push_addr_i;
  logic [31:0]   push_addr_2_i;
  logic          flush_i;
  logic          full_o;
  logic          empty_o;
  logic [CW-1:0] count_o;
  logic          overflow_o;

  logic          hermes_send_active_i;
  logic          hermes_receive_active_i;
  logic          hermes_start_o;
  logic          hermes_operation_o;
  logic [31:0]   hermes_size_o;
  logic [31:0]   hermes_size_2_o;
  logic [31:0]   hermes_address_o;
  logic [31:0]   hermes_address_2_o;
  logic          busy_o;
  logic          done_o;
  logic          error_o;
  logic [1:0]    state_o;

  modport master (
    output push_i, push_op_i, push_size_i, push_size_2_i, push_addr_i, push_addr_2_i,
    output flush_i, hermes_send_active_i, hermes_receive_active_i,
    input  full_o, empty_o, count_o, overflow_o,
    input  hermes_start_o, hermes_operation_o, hermes_size_o, hermes_size_2_o,
    input  hermes_address_o, hermes_address_2_o, busy_o, done_o, error_o, state_o
  );

  modport slave (
    input  push_i, push_op_i, push_size_i, push_size_2_i, push_addr_i, push_addr_2_i,
    input  flush_i, hermes_send_active_i, hermes_receive_active_i,
    output full_o, empty_o, count_o, overflow_o,
    output hermes_start_o, hermes_operation_o, hermes_size_o, hermes_size_2_o,
    output hermes_address_o, hermes_address_2_o, busy_o, done_o, error_o, state_o
  );
endinterface

// File: rtl/hermes_cmd_queue.sv
// Command FIFO in front of the Hermes DMA engine; issues one command at a time and waits for completion.
// Optional WAIT_ACT watchdog enabled by defining HERMES_CMDQ_TIMEOUT_EN.
module hermes_cmd_queue #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic               clk_i,
  input logic               rst_ni,
  hermes_cmd_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACT, WAIT_DONE} state_e;

  typedef struct packed {
    logic        op;
    logic [31:0] size;
    logic [31:0] size_2;
    logic [31:0] addr;
    logic [31:0] addr_2;
  } cmd_t;

  cmd_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  state_e        state_q, state_d;

  logic          op_q;
  logic [31:0]   size_q, size_2_q, addr_q, addr_2_q;

  logic full, empty, busy, sel, push_ok, overflow;
  logic pop, load, start, done;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign busy     = (state_q != IDLE);
  assign sel      = op_q ? bus.hermes_receive_active_i : bus.hermes_send_active_i;
  // A full queue still takes a push when the head retires in the same cycle.
  assign push_ok  = bus.push_i && !bus.flush_i && (!full || pop);
  assign overflow = bus.push_i && !bus.flush_i && full && !pop;

`ifdef HERMES_CMDQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q;
  logic          time_out;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt_q <= '0;
    end else if (state_q == WAIT_ACT) begin
      to_cnt_q <= to_cnt_q + TW'(1);
    end else begin
      to_cnt_q <= '0;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    load    = 1'b0;
    start   = 1'b0;
    done    = 1'b0;
`ifdef HERMES_CMDQ_TIMEOUT_EN
    time_out = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!empty && !bus.hermes_send_active_i && !bus.hermes_receive_active_i) begin
          load    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        start   = 1'b1;
        state_d = WAIT_ACT;
      end
      WAIT_ACT: begin
        if (sel) begin
          state_d = WAIT_DONE;
        end
`ifdef HERMES_CMDQ_TIMEOUT_EN
        else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          pop      = 1'b1;
          time_out = 1'b1;
          state_d  = IDLE;
        end
`endif
      end
      WAIT_DONE: begin
        if (!sel) begin
          pop     = 1'b1;
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Flush keeps only the in-flight head; if that head retires this cycle nothing remains.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (bus.flush_i) begin
        wr_ptr_q <= rd_ptr_q + PW'(busy);
        count_q  <= CW'(busy && !pop);
      end else begin
        if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
        case ({push_ok, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= '{op:     bus.push_op_i,
                         size:   bus.push_size_i,
                         size_2: bus.push_size_2_i,
                         addr:   bus.push_addr_i,
                         addr_2: bus.push_addr_2_i};
    end
  end

  // Fields are captured on entry to ISSUE so they are valid alongside the start pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q     <= 1'b0;
      size_q   <= '0;
      size_2_q <= '0;
      addr_q   <= '0;
      addr_2_q <= '0;
    end else if (load) begin
      op_q     <= mem[rd_ptr_q].op;
      size_q   <= mem[rd_ptr_q].size;
      size_2_q <= mem[rd_ptr_q].size_2;
      addr_q   <= mem[rd_ptr_q].addr;
      addr_2_q <= mem[rd_ptr_q].addr_2;
    end
  end

  assign bus.full_o             = full;
  assign bus.empty_o            = empty;
  assign bus.count_o            = count_q;
  assign bus.overflow_o         = overflow;
  assign bus.hermes_start_o     = start;
  assign bus.hermes_operation_o = op_q;
  assign bus.hermes_size_o      = size_q;
  assign bus.hermes_size_2_o    = size_2_q;
  assign bus.hermes_address_o   = addr_q;
  assign bus.hermes_address_2_o = addr_2_q;
  assign bus.busy_o             = busy;
  assign bus.done_o             = done;
  assign bus.state_o            = state_q;
`ifdef HERMES_CMDQ_TIMEOUT_EN
  assign bus.error_o            = time_out;
`else
  assign bus.error_o            = 1'b0;
`endif
endmodule
